// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared types and constants for the partial-sum accumulator.
// Holds the FSM state encoding and the default lane geometry used by the
// top level and by the single-lane saturating adder.
package psum_accum_pkg;

    // Default lane geometry; the top level exposes these as overridable parameters.
    localparam int PSUM_BW_DEFAULT = 16;
    localparam int COL_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT   = 16;

    // Accumulator FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/psum_accum_if.sv
// psum_accum_if: partial-sum input stream and final-pixel output stream.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// exactly when valid and ready are both high. The producer holds data stable
// while valid is high and ready is low; ready may depend on state but never
// on valid.
interface psum_accum_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [psum_bw*col-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [psum_bw*col-1:0]   out_data;

    // Upstream core plus downstream sink side.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Accumulator side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/psum_accum_sat_add_lane.sv
// sat_add_lane: one signed lane of a saturating adder. The sum is formed one
// bit wider than the operands; disagreement of the top two bits marks an
// overflow, and the wide sign bit picks which rail to clamp to.
module sat_add_lane
    import psum_accum_pkg::*;
#(
    parameter int W = PSUM_BW_DEFAULT
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] sum_w;

    // Widened add followed by clamp to the signed W-bit range.
    always_comb begin
        sum_w = {a[W-1], a} + {b[W-1], b};
        if (sum_w[W] != sum_w[W-1]) begin
            y = sum_w[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = sum_w[W-1:0];
        end
    end

endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates per-pixel partial sums over several kernel passes
// and then drains the finished pixels downstream.
//
// A job is nout pixels by npass passes. Pass 0 stores each beat as-is; later
// passes add the beat to the stored pixel with per-lane signed saturation.
// After the last beat of the last pass the buffer is streamed out in pixel
// order, and done pulses once the final pixel has been taken.
//
// Optional build macro: PSUM_ACCUM_RELU_EN clamps negative lanes to zero on
// the drain path; without it lanes leave unmodified.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int col     = COL_DEFAULT,
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int depth   = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               cfg_npass,
    input  logic [$clog2(depth):0]   cfg_nout,
    psum_accum_if.slave              io,
    output logic                     busy,
    output logic                     done,
    output state_t                   dbg_state
);

    localparam int DW = psum_bw * col;
    localparam int NW = $clog2(depth) + 1;
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    // Control registers.
    state_t          state_q,  state_d;
    logic [3:0]      pass_q,   pass_d;
    logic [3:0]      npass_q,  npass_d;
    logic [NW-1:0]   nout_q,   nout_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            done_q,   done_d;

    // Pixel buffer; contents are don't-care until a job's pass 0 writes them.
    logic [DW-1:0]   mem_q [depth];

    logic            accept;
    logic            emit;
    logic            last_addr;
    logic            last_pass;
    logic            last_rd;
    logic [3:0]      npass_eff;
    logic [NW-1:0]   nout_eff;
    logic [DW-1:0]   acc_word;
    logic [DW-1:0]   sum_word;
    logic [DW-1:0]   wr_word;
    logic [DW-1:0]   out_word;

    assign accept    = io.in_valid && (state_q == ACCUM);
    assign emit      = io.out_ready && (state_q == DRAIN);
    assign last_addr = ({{(NW-AW){1'b0}}, wr_addr_q} == (nout_q - NW'(1)));
    assign last_pass = (pass_q == (npass_q - 4'd1));
    assign last_rd   = ({{(NW-AW){1'b0}}, rd_addr_q} == (nout_q - NW'(1)));

    // Job configuration sanitised at start: zero means one, nout capped at depth.
    always_comb begin
        npass_eff = (cfg_npass == 4'd0) ? 4'd1 : cfg_npass;
        if (cfg_nout == '0) begin
            nout_eff = NW'(1);
        end else if (cfg_nout > NW'(depth)) begin
            nout_eff = NW'(depth);
        end else begin
            nout_eff = cfg_nout;
        end
    end

    // Saturating adders for every lane: stored pixel plus incoming beat.
    assign acc_word = mem_q[wr_addr_q];

    for (genvar g = 0; g < col; g++) begin : g_lane
        sat_add_lane #(
            .W (psum_bw)
        ) u_sat_add_lane (
            .a (acc_word[g*psum_bw +: psum_bw]),
            .b (io.in_data[g*psum_bw +: psum_bw]),
            .y (sum_word[g*psum_bw +: psum_bw])
        );
    end

    // Pass 0 overwrites whatever an earlier job left; later passes accumulate.
    assign wr_word = (pass_q == 4'd0) ? io.in_data : sum_word;

    // Buffer write port, one accepted beat per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_addr_q] <= wr_word;
        end
    end

    // FSM next-state, pointer and pass bookkeeping.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        npass_d   = npass_q;
        nout_d    = nout_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    npass_d   = npass_eff;
                    nout_d    = nout_eff;
                    pass_d    = 4'd0;
                    wr_addr_d = '0;
                    rd_addr_d = '0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (last_addr) begin
                        wr_addr_d = '0;
                        if (last_pass) begin
                            state_d   = DRAIN;
                            rd_addr_d = '0;
                        end else begin
                            pass_d = pass_q + 4'd1;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (emit) begin
                    if (last_rd) begin
                        state_d   = IDLE;
                        rd_addr_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pass_q    <= 4'd0;
            npass_q   <= 4'd1;
            nout_q    <= NW'(1);
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            npass_q   <= npass_d;
            nout_q    <= nout_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
        end
    end

    // Drain data path; zero outside DRAIN so reset and idle present a clean bus.
    always_comb begin
        out_word = '0;
        if (state_q == DRAIN) begin
`ifdef PSUM_ACCUM_RELU_EN
            for (int l = 0; l < col; l++) begin
                if (mem_q[rd_addr_q][l*psum_bw + psum_bw - 1]) begin
                    out_word[l*psum_bw +: psum_bw] = '0;
                end else begin
                    out_word[l*psum_bw +: psum_bw] = mem_q[rd_addr_q][l*psum_bw +: psum_bw];
                end
            end
`else
            out_word = mem_q[rd_addr_q];
`endif
        end
    end

    assign io.in_ready  = (state_q == ACCUM);
    assign io.out_valid = (state_q == DRAIN);
    assign io.out_data  = out_word;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed bench for psum_accum with default geometry
// (8 lanes x 16 bits, depth 16). Expected pixels are hand-derived and queued
// in exp_q; the drain task pops them as pixels are accepted.
module tb_psum_accum;
    import psum_accum_pkg::*;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;
    localparam int DW    = COL * BW;
    localparam int NW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    cfg_npass;
    logic [NW-1:0] cfg_nout;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];

    psum_accum_if #(.col(COL), .psum_bw(BW)) io ();

    psum_accum #(
        .col     (COL),
        .psum_bw (BW),
        .depth   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_npass (cfg_npass),
        .cfg_nout  (cfg_nout),
        .io        (io),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // All lanes equal to v.
    function automatic logic [DW-1:0] rep(input int v);
        logic [BW-1:0] t;
        logic [DW-1:0] r;
        t = v[BW-1:0];
        for (int l = 0; l < COL; l++) r[l*BW +: BW] = t;
        return r;
    endfunction

    // Lane 0 equal to v, other lanes zero.
    function automatic logic [DW-1:0] lane0(input int v);
        logic [DW-1:0] r;
        r = '0;
        r[BW-1:0] = v[BW-1:0];
        return r;
    endfunction

    // Drain post-processing as seen by the sink.
    function automatic logic [DW-1:0] post(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = x;
`ifdef PSUM_ACCUM_RELU_EN
        for (int l = 0; l < COL; l++) begin
            if (x[l*BW + BW - 1]) r[l*BW +: BW] = '0;
        end
`endif
        return r;
    endfunction

    // Per-lane distinct pixel pattern for the stall test.
    function automatic logic [DW-1:0] pix(input int i);
        logic [DW-1:0] r;
        int v;
        for (int l = 0; l < COL; l++) begin
            v = i * 100 - l * 37 - 200;
            r[l*BW +: BW] = v[BW-1:0];
        end
        return r;
    endfunction

    // Driver: pulse start with a configuration (entered and left on a negedge).
    task automatic start_job(input logic [3:0] np, input logic [NW-1:0] no);
        start     = 1'b1;
        cfg_npass = np;
        cfg_nout  = no;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Driver: present one beat until accepted (bounded).
    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        io.in_valid = 1'b1;
        io.in_data  = d;
        while (!io.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            check("in_ready_timeout", DW'(io.in_ready), DW'(1));
        end else begin
            @(negedge clk);
        end
        io.in_valid = 1'b0;
    endtask

    // Sink: take n pixels, optionally with random back-pressure, and check done.
    task automatic drain(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            int  guard;
            bit  got;
            guard = 0;
            got   = 1'b0;
            while (!got && guard < 200) begin
                io.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (io.out_valid) begin
                    check("pixel", io.out_data, exp_q[0]);
                    if (io.out_ready) begin
                        void'(exp_q.pop_front());
                        got = 1'b1;
                    end
                end
                @(negedge clk);
                guard++;
            end
            if (!got) check("drain_timeout", DW'(io.out_valid), DW'(1));
        end
        io.out_ready = 1'b0;
        check("done_pulse", DW'(done), DW'(1));
        check("idle_after_drain", DW'(busy), DW'(0));
        check("exp_q_empty", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        cfg_npass   = 4'd0;
        cfg_nout    = '0;
        io.in_valid = 1'b0;
        io.in_data  = '0;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy",      DW'(busy),         DW'(0));
        check("rst_in_ready",  DW'(io.in_ready),  DW'(0));
        check("rst_out_valid", DW'(io.out_valid), DW'(0));
        check("rst_done",      DW'(done),         DW'(0));
        check("rst_out_data",  io.out_data,       DW'(0));
        check("rst_state",     DW'(dbg_state),    DW'(0));
        reset = 1'b0;
        @(negedge clk);

        // npass=1, nout=4, pixels k=1..4.
        start_job(4'd1, NW'(4));
        check("job1_busy",     DW'(busy),        DW'(1));
        check("job1_in_ready", DW'(io.in_ready), DW'(1));
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(post(rep(k)));
            send_beat(rep(k));
        end
        check("job1_drain_in_ready",  DW'(io.in_ready),  DW'(0));
        check("job1_drain_out_valid", DW'(io.out_valid), DW'(1));
        drain(4, 1'b0);

        // Start on the done cycle; zero configuration means one pass, one pixel.
        start_job(4'd0, NW'(0));
        check("start_on_done_busy", DW'(busy), DW'(1));
        exp_q.push_back(post(rep(42)));
        send_beat(rep(42));
        drain(1, 1'b0);
        @(negedge clk);
        check("done_single_cycle", DW'(done), DW'(0));

        // npass=9, nout=16, +100 per beat; a stray start mid-job is ignored.
        start_job(4'd9, NW'(16));
        for (int p = 0; p < 9; p++) begin
            for (int a = 0; a < 16; a++) begin
                send_beat(rep(100));
                if (p == 0 && a == 2) start_job(4'd1, NW'(1));
            end
        end
        for (int a = 0; a < 16; a++) exp_q.push_back(post(rep(900)));
        drain(16, 1'b0);
        @(negedge clk);
        check("job9_done_low", DW'(done), DW'(0));

        // Saturation at both rails on lane 0.
        start_job(4'd2, NW'(2));
        send_beat(lane0(32767));
        send_beat(lane0(-32768));
        send_beat(lane0(5));
        send_beat(lane0(-1));
        exp_q.push_back(post(lane0(32767)));
        exp_q.push_back(post(lane0(-32768)));
        drain(2, 1'b0);

        // Negative and positive lanes through the drain post-processing.
        start_job(4'd1, NW'(2));
        send_beat(rep(-7));
        send_beat(rep(3));
`ifdef PSUM_ACCUM_RELU_EN
        exp_q.push_back(rep(0));
`else
        exp_q.push_back(rep(-7));
`endif
        exp_q.push_back(rep(3));
        drain(2, 1'b0);

        // nout above depth is clamped to depth.
        start_job(4'd1, NW'(20));
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(post(rep(i * 7 - 50)));
            send_beat(rep(i * 7 - 50));
        end
        check("clamp_in_drain", DW'(io.in_ready), DW'(0));
        drain(16, 1'b0);

        // Random back-pressure during drain.
        start_job(4'd1, NW'(8));
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(post(pix(i)));
            send_beat(pix(i));
        end
        drain(8, 1'b1);

        // Reset in the middle of accumulation, then a fresh job.
        start_job(4'd2, NW'(4));
        for (int i = 0; i < 5; i++) send_beat(rep(77));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",      DW'(busy),         DW'(0));
        check("midrst_in_ready",  DW'(io.in_ready),  DW'(0));
        check("midrst_out_valid", DW'(io.out_valid), DW'(0));
        check("midrst_out_data",  io.out_data,       DW'(0));
        io.in_valid = 1'b1;
        io.in_data  = rep(999);
        check("idle_in_ready", DW'(io.in_ready), DW'(0));
        @(negedge clk);
        io.in_valid = 1'b0;
        check("idle_ignores_beat", DW'(busy), DW'(0));
        start_job(4'd1, NW'(2));
        send_beat(rep(11));
        send_beat(rep(-22));
        exp_q.push_back(post(rep(11)));
        exp_q.push_back(post(rep(-22)));
        drain(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
